// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types and helpers for the glitch pulse generator.
//   glitch_state_t : controller state encoding
//   DEF_*          : default field widths / synchroniser depth
//   sub1_min1      : terminal count for an interval, with 0 treated as 1
package glitch_pkg;

   localparam int unsigned DEF_DELAY_W     = 24;
   localparam int unsigned DEF_WIDTH_W     = 16;
   localparam int unsigned DEF_COUNT_W     = 8;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      StIdle,
      StArmed,
      StDelay,
      StPulse,
      StGap
   } glitch_state_t;

   // An N-cycle interval ends when a counter started at 0 reaches N-1.
   // A zero request is stretched to one cycle, so its terminal is also 0.
   function automatic logic [31:0] sub1_min1(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// trig_sync_edge: brings the asynchronous trigger level into clk and flags
// its rising edge.
// Ports:
//   clk       in   fabric clock
//   rst_n     in   synchronous active-low reset (clears all flops)
//   trigger   in   asynchronous trigger level
//   trig_rise out  high for exactly one cycle when the synchronised level goes 0->1
module trig_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trigger,
   output logic trig_rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign trig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen: after an armed trigger edge, waits delay_cycles and then
// emits pulse_count pulses of width_cycles high / gap_cycles low on glitch_out.
// Ports:
//   clk, rst_n        fabric clock, synchronous active-low reset
//   trigger           asynchronous level from the upstream trigger block
//   arm / disarm      one-cycle requests (disarm wins, works from any state)
//   delay_cycles      trigger-edge to first pulse delay
//   width_cycles      pulse high time (0 -> 1)
//   gap_cycles        low time between pulses (0 -> 1)
//   pulse_count       pulses per trigger (0 -> 1)
//   glitch_out        registered glitch drive
//   armed, busy       state indications
//   done              one-cycle strobe after the last pulse
//   timeout           one-cycle strobe on armed timeout
// Build option: define GLITCH_ARM_TIMEOUT_EN to give up waiting in ARMED after
// TIMEOUT_CYCLES cycles; otherwise ARMED waits forever and timeout is 0.
module glitch_pulse_gen
   import glitch_pkg::*;
#(
   parameter int unsigned DELAY_W        = DEF_DELAY_W,
   parameter int unsigned WIDTH_W        = DEF_WIDTH_W,
   parameter int unsigned COUNT_W        = DEF_COUNT_W,
   parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               trigger,
   input  logic               arm,
   input  logic               disarm,
   input  logic [DELAY_W-1:0] delay_cycles,
   input  logic [WIDTH_W-1:0] width_cycles,
   input  logic [WIDTH_W-1:0] gap_cycles,
   input  logic [COUNT_W-1:0] pulse_count,
   output logic               glitch_out,
   output logic               armed,
   output logic               busy,
   output logic               done,
   output logic               timeout
);

   localparam int unsigned CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

   glitch_state_t      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COUNT_W-1:0] remain_q, remain_d;
   logic [DELAY_W-1:0] delay_q;
   logic [WIDTH_W-1:0] width_last_q, gap_last_q;
   logic               entry_q;
   logic               glitch_q, done_q, done_d;
   logic               trig_rise, fire, cfg_load;
   logic [CNT_W-1:0]   delay_last;

   trig_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .trigger   (trigger),
      .trig_rise (trig_rise)
   );

   // An edge seen in the first ARMED cycle was already in flight at arm time.
   assign fire       = trig_rise & ~entry_q;
   assign cfg_load   = (state_q == StIdle) & arm & ~disarm;
   assign delay_last = CNT_W'(delay_q) - CNT_W'(1);

`ifdef GLITCH_ARM_TIMEOUT_EN
   logic [31:0] tmo_q;
   logic        timeout_q, timeout_d;

   always_ff @(posedge clk) begin
      if (!rst_n || state_q != StArmed) begin
         tmo_q <= 32'd0;
      end else begin
         tmo_q <= tmo_q + 32'd1;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      remain_d = remain_q;
      done_d   = 1'b0;
`ifdef GLITCH_ARM_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (arm) begin
               state_d  = StArmed;
               remain_d = (pulse_count == '0) ? COUNT_W'(1) : pulse_count;
            end
         end
         StArmed: begin
            if (fire) begin
               cnt_d   = '0;
               // Zero delay skips DELAY so the pulse lands on the next cycle.
               state_d = (delay_q == '0) ? StPulse : StDelay;
            end
`ifdef GLITCH_ARM_TIMEOUT_EN
            else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
            end
`endif
         end
         StDelay: begin
            if (cnt_q == delay_last) begin
               cnt_d   = '0;
               state_d = StPulse;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPulse: begin
            if (cnt_q == CNT_W'(width_last_q)) begin
               cnt_d = '0;
               if (remain_q > COUNT_W'(1)) begin
                  remain_d = remain_q - COUNT_W'(1);
                  state_d  = StGap;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StGap: begin
            if (cnt_q == CNT_W'(gap_last_q)) begin
               cnt_d   = '0;
               state_d = StPulse;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (disarm) begin
         state_d = StIdle;
         cnt_d   = '0;
         done_d  = 1'b0;
`ifdef GLITCH_ARM_TIMEOUT_EN
         timeout_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         remain_q     <= '0;
         delay_q      <= '0;
         width_last_q <= '0;
         gap_last_q   <= '0;
         entry_q      <= 1'b0;
         glitch_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         remain_q <= remain_d;
         entry_q  <= (state_q == StIdle) && (state_d == StArmed);
         glitch_q <= (state_d == StPulse);
         done_q   <= done_d;
         if (cfg_load) begin
            delay_q      <= delay_cycles;
            width_last_q <= WIDTH_W'(sub1_min1(32'(width_cycles)));
            gap_last_q   <= WIDTH_W'(sub1_min1(32'(gap_cycles)));
         end
      end
   end

`ifdef GLITCH_ARM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign glitch_out = glitch_q;
   assign done       = done_q;
   assign armed      = (state_q == StArmed);
   assign busy       = (state_q == StDelay) || (state_q == StPulse) || (state_q == StGap);

endmodule
